// File: rtl/tl_pkg.sv
// Shared types and constants for the traffic phase scheduler.
package tl_pkg;

  localparam int CNT_W = 7;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t CNT_MAX = 7'd127;

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  typedef enum logic [2:0] {
    AR_TO_NS  = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    AR_TO_EW  = 3'd3,
    EW_GREEN  = 3'd4,
    EW_YELLOW = 3'd5,
    PED_WALK  = 3'd6
  } state_t;

endpackage

// File: rtl/phase_timer.sv
// Elapsed-cycle counter for the current phase: restart to 0, count up, hold at 127.
module phase_timer
  import tl_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic restart_i,
  output cnt_t count_o
);

  cnt_t count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (restart_i) begin
      count_d = '0;
    end else if (count_q != CNT_MAX) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Two-approach traffic light sequencer with sticky vehicle requests.
// Define TL_PED_EN to build in the pedestrian walk phase.
//
// state     | meaning
// AR_TO_NS  | all-red clearance before north-south green
// NS_GREEN  | north-south green, holds until east-west (or walk) demand
// NS_YELLOW | north-south yellow
// AR_TO_EW  | all-red clearance before east-west green
// EW_GREEN  | east-west green, holds until north-south (or walk) demand
// EW_YELLOW | east-west yellow
// PED_WALK  | all-red with walk lamp (TL_PED_EN only)
module traffic_phase_scheduler
  import tl_pkg::*;
#(
  parameter int MIN_GREEN = 20,
  parameter int MAX_GREEN = 60,
  parameter int YELLOW_T  = 5,
  parameter int ALLRED_T  = 2,
  parameter int PED_T     = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ns_sensor,
  input  logic       ew_sensor,
  input  logic       ped_req,
  output logic [2:0] NS,
  output logic [2:0] EW,
  output logic       walk,
  output logic [6:0] count,
  output logic       SW
);

  if (MIN_GREEN < 1 || MIN_GREEN > 127 || MAX_GREEN < 1 || MAX_GREEN > 127 ||
      YELLOW_T < 1 || YELLOW_T > 127 || ALLRED_T < 1 || ALLRED_T > 127 ||
      PED_T < 1 || PED_T > 127 || MIN_GREEN > MAX_GREEN) begin : g_param_err
    $error("traffic_phase_scheduler: timing parameter out of range");
  end

  localparam cnt_t MIN_CNT = cnt_t'(MIN_GREEN - 1);
  localparam cnt_t MAX_CNT = cnt_t'(MAX_GREEN - 1);
  localparam cnt_t YEL_CNT = cnt_t'(YELLOW_T - 1);
  localparam cnt_t AR_CNT  = cnt_t'(ALLRED_T - 1);
  localparam cnt_t PED_CNT = cnt_t'(PED_T - 1);

  state_t state_q, state_d;
  logic   started_q;
  logic   sw_q, sw_d;
  logic   ns_pend_q, ns_pend_d;
  logic   ew_pend_q, ew_pend_d;
  logic   ns_eff, ew_eff, ped_eff;
  logic   walk_to_ns;
  logic   green_done;
  cnt_t   cnt;

  phase_timer u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .restart_i (sw_d),
    .count_o   (cnt)
  );

  assign count = cnt;

  // A request arriving this cycle counts immediately; the flag keeps it for later.
  assign ns_eff = ns_pend_q | ns_sensor;
  assign ew_eff = ew_pend_q | ew_sensor;

  assign green_done = (cnt >= MIN_CNT) || (cnt >= MAX_CNT);

`ifdef TL_PED_EN
  logic ped_pend_q, ped_pend_d;
  logic walk_to_ns_q;

  assign ped_eff    = ped_pend_q | ped_req;
  assign ped_pend_d = ped_eff & ~(state_d == PED_WALK && state_q != PED_WALK);
  assign walk_to_ns = walk_to_ns_q;
  assign walk       = (state_q == PED_WALK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ped_pend_q   <= 1'b0;
      walk_to_ns_q <= 1'b0;
    end else begin
      ped_pend_q <= ped_pend_d;
      if (state_d == PED_WALK && state_q != PED_WALK) begin
        walk_to_ns_q <= (state_q == EW_YELLOW);
      end
    end
  end
`else
  logic ped_unused;

  assign ped_unused = ped_req;
  assign ped_eff    = 1'b0;
  assign walk_to_ns = 1'b0;
  assign walk       = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      AR_TO_NS:  if (started_q && cnt >= AR_CNT) state_d = NS_GREEN;
      NS_GREEN:  if ((ew_eff || ped_eff) && green_done) state_d = NS_YELLOW;
      NS_YELLOW: if (cnt >= YEL_CNT) state_d = ped_eff ? PED_WALK : AR_TO_EW;
      AR_TO_EW:  if (cnt >= AR_CNT) state_d = EW_GREEN;
      EW_GREEN:  if ((ns_eff || ped_eff) && green_done) state_d = EW_YELLOW;
      EW_YELLOW: if (cnt >= YEL_CNT) state_d = ped_eff ? PED_WALK : AR_TO_NS;
      PED_WALK:  if (cnt >= PED_CNT) state_d = walk_to_ns ? AR_TO_NS : AR_TO_EW;
      default:   state_d = AR_TO_NS;
    endcase
  end

  // The first edge after reset release is treated as entry into AR_TO_NS.
  assign sw_d      = (state_d != state_q) || !started_q;
  assign ns_pend_d = ns_eff & ~(state_d == NS_GREEN && state_q != NS_GREEN);
  assign ew_pend_d = ew_eff & ~(state_d == EW_GREEN && state_q != EW_GREEN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= AR_TO_NS;
      started_q <= 1'b0;
      sw_q      <= 1'b0;
      ns_pend_q <= 1'b0;
      ew_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      started_q <= 1'b1;
      sw_q      <= sw_d;
      ns_pend_q <= ns_pend_d;
      ew_pend_q <= ew_pend_d;
    end
  end

  assign SW = sw_q;

  always_comb begin
    NS = LAMP_RED;
    EW = LAMP_RED;
    case (state_q)
      NS_GREEN:  NS = LAMP_GREEN;
      NS_YELLOW: NS = LAMP_YELLOW;
      EW_GREEN:  EW = LAMP_GREEN;
      EW_YELLOW: EW = LAMP_YELLOW;
      default:   ;
    endcase
  end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed scoreboard bench for traffic_phase_scheduler (default timing parameters).
module tb_traffic_phase_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ns_sensor = 1'b0;
  logic       ew_sensor = 1'b0;
  logic       ped_req = 1'b0;
  logic [2:0] NS, EW;
  logic       walk, SW;
  logic [6:0] count;

  int checks = 0;
  int failures = 0;
  int sw_pulses = 0;

  typedef struct {
    string      tag;
    logic [2:0] ns;
    logic [2:0] ew;
    logic [6:0] cnt;
    logic       sw;
    logic       wk;
  } exp_t;

  exp_t sb[$];

  traffic_phase_scheduler dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ns_sensor (ns_sensor),
    .ew_sensor (ew_sensor),
    .ped_req   (ped_req),
    .NS        (NS),
    .EW        (EW),
    .walk      (walk),
    .count     (count),
    .SW        (SW)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [2:0] ns, input logic [2:0] ew,
                      input int c, input logic wk);
    exp_t e;
    e.tag = tag;
    e.ns  = ns;
    e.ew  = ew;
    e.cnt = 7'((c > 127) ? 127 : c);
    e.sw  = (c == 0);
    e.wk  = wk;
    sb.push_back(e);
  endtask

  task automatic push_green(input bit ns_dir, input int from, input int to);
    for (int c = from; c <= to; c++) begin
      if (ns_dir) push("ns_green", 3'b001, 3'b100, c, 1'b0);
      else        push("ew_green", 3'b100, 3'b001, c, 1'b0);
    end
  endtask

  task automatic push_yellow(input bit ns_dir, input int from, input int to);
    for (int c = from; c <= to; c++) begin
      if (ns_dir) push("ns_yellow", 3'b010, 3'b100, c, 1'b0);
      else        push("ew_yellow", 3'b100, 3'b010, c, 1'b0);
    end
  endtask

  task automatic push_ar();
    for (int c = 0; c < 2; c++) push("allred", 3'b100, 3'b100, c, 1'b0);
  endtask

  task automatic check_head();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL scoreboard_empty observed=0 expected=entry");
    end else begin
      e = sb.pop_front();
      check({e.tag, ".NS"}, 8'(NS), 8'(e.ns));
      check({e.tag, ".EW"}, 8'(EW), 8'(e.ew));
      check({e.tag, ".count"}, 8'(count), 8'(e.cnt));
      check({e.tag, ".SW"}, 8'(SW), 8'(e.sw));
      check({e.tag, ".walk"}, 8'(walk), 8'(e.wk));
    end
  endtask

  task automatic drain();
    while (sb.size() > 0) begin
      @(negedge clk);
      check_head();
    end
  endtask

  task automatic wait_for(input string tag, input logic [2:0] ns, input logic [2:0] ew,
                          input logic [6:0] c, input int budget);
    bit found = 1'b0;
    int n = 0;
    while (!found && n < budget) begin
      @(negedge clk);
      n++;
      if (NS === ns && EW === ew && count === c) found = 1'b1;
    end
    check({tag, ".reached"}, 8'(found), 8'd1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".NS"}, 8'(NS), 8'h04);
    check({tag, ".EW"}, 8'(EW), 8'h04);
    check({tag, ".count"}, 8'(count), 8'h00);
    check({tag, ".SW"}, 8'(SW), 8'h00);
    check({tag, ".walk"}, 8'(walk), 8'h00);
  endtask

  // Safety invariants sampled every cycle outside reset.
  logic [2:0] ns_prev = 3'b100;
  logic [2:0] ew_prev = 3'b100;
  always @(negedge clk) begin
    if (rst_n) begin
      check("both_non_red", 8'(NS != 3'b100 && EW != 3'b100), 8'd0);
      check("ns_red_to_yellow", 8'(ns_prev == 3'b100 && NS == 3'b010), 8'd0);
      check("ew_red_to_yellow", 8'(ew_prev == 3'b100 && EW == 3'b010), 8'd0);
`ifndef TL_PED_EN
      check("walk_tied_low", 8'(walk), 8'd0);
`endif
      if (SW) sw_pulses++;
      ns_prev = NS;
      ew_prev = EW;
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    check_reset_state("reset");

    // Release: 2 all-red cycles, then north-south green held for 500 cycles.
    rst_n = 1'b1;
    push_ar();
    push_green(1'b1, 0, 499);
    drain();
    check("sw_pulses_500", 8'(sw_pulses), 8'd2);

    // Late east-west request: yields on the next edge.
    push_yellow(1'b1, 0, 4);
    push_ar();
    push_green(1'b0, 0, 0);
    ew_sensor = 1'b1;
    @(negedge clk);
    ew_sensor = 1'b0;
    check_head();
    drain();

    // North-south request at EW count 30.
    wait_for("ew_cnt30", 3'b100, 3'b001, 7'd30, 64);
    push_yellow(1'b0, 0, 4);
    push_ar();
    push_green(1'b1, 0, 0);
    ns_sensor = 1'b1;
    @(negedge clk);
    ns_sensor = 1'b0;
    check_head();
    drain();

    // Early east-west pulse at NS count 5: green still runs to count 19.
    wait_for("ns_cnt5", 3'b001, 3'b100, 7'd5, 32);
    push_green(1'b1, 6, 19);
    push_yellow(1'b1, 0, 4);
    push_ar();
    push_green(1'b0, 0, 0);
    ew_sensor = 1'b1;
    @(negedge clk);
    ew_sensor = 1'b0;
    check_head();
    drain();

    // Both sensors held: every green is exactly 20 cycles.
    ns_sensor = 1'b1;
    ew_sensor = 1'b1;
    push_green(1'b0, 1, 19);
    push_yellow(1'b0, 0, 4);
    push_ar();
    push_green(1'b1, 0, 19);
    push_yellow(1'b1, 0, 4);
    push_ar();
    push_green(1'b0, 0, 19);
    push_yellow(1'b0, 0, 4);
    push_ar();
    push_green(1'b1, 0, 19);
    push_yellow(1'b1, 0, 2);
    drain();

    // Reset in the middle of NS yellow acts before the next clock edge.
    #2 rst_n = 1'b0;
    #1 check_reset_state("reset_mid_yellow");
    ns_sensor = 1'b0;
    ew_sensor = 1'b0;
    @(negedge clk);
    check_reset_state("reset_held");
    rst_n = 1'b1;
    push_ar();
    push_green(1'b1, 0, 99);
    drain();

`ifdef TL_PED_EN
    push_yellow(1'b1, 0, 4);
    for (int c = 0; c < 15; c++) push("ped_walk", 3'b100, 3'b100, c, 1'b1);
    push_ar();
    push_green(1'b0, 0, 20);
`else
    push_green(1'b1, 100, 129);
`endif
    ped_req = 1'b1;
    @(negedge clk);
    ped_req = 1'b0;
    check_head();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/traffic_phase_scheduler.md
TRAFFIC_PHASE_SCHEDULER -- requirements
Module: traffic_phase_scheduler

Interface
REQ-001 Parameter MIN_GREEN, default 20: minimum green cycles before a phase may yield.
REQ-002 Parameter MAX_GREEN, default 60: green cycles after which a phase yields to a pending request.
REQ-003 Parameter YELLOW_T, default 5: yellow duration in cycles.
REQ-004 Parameter ALLRED_T, default 2: all-red clearance in cycles.
REQ-005 Parameter PED_T, default 15: pedestrian walk duration in cycles (TL_PED_EN builds only).
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 ns_sensor  in  1  vehicle present on north-south approach.
REQ-009 ew_sensor  in  1  vehicle present on east-west approach.
REQ-010 ped_req  in  1  pedestrian button; ignored unless TL_PED_EN is defined.
REQ-011 NS  out  3  north-south lamp, one-hot {red,yellow,green}.
REQ-012 EW  out  3  east-west lamp, one-hot {red,yellow,green}.
REQ-013 walk  out  1  pedestrian walk lamp.
REQ-014 count  out  7  elapsed cycles in current state, 0-based.
REQ-015 SW  out  1  one-cycle pulse on the first cycle of every new state.

Function
REQ-016 States: AR_TO_NS, NS_GREEN, NS_YELLOW, AR_TO_EW, EW_GREEN, EW_YELLOW, and PED_WALK (TL_PED_EN only).
REQ-017 Lamps: green state drives own approach 3'b001 and other 3'b100; yellow drives 3'b010/3'b100; AR_* and PED_WALK drive both 3'b100.
REQ-018 count resets to 0 on state entry, increments each cycle, saturates at 127.
REQ-019 ew_sensor sets sticky ew_pend; cleared on the cycle EW_GREEN is entered. ns_sensor/ns_pend symmetric with NS_GREEN.
REQ-020 Green exits to yellow when opposite pend=1 and count>=MIN_GREEN-1, or count>=MAX_GREEN-1 with opposite pend=1; with opposite pend=0 green holds indefinitely.
REQ-021 Sensor asserted on the cycle green exits is still latched and served next turn.
REQ-022 Yellow lasts exactly YELLOW_T cycles, then AR_TO_<other> (or PED_WALK, REQ-031).
REQ-023 AR_TO_x lasts exactly ALLRED_T cycles, then x_GREEN.
REQ-024 No cycle ever has both NS and EW outside red; yellow never directly follows red.
REQ-025 SW is registered, high only on the first cycle of each state, including first state after reset.
REQ-026 Parameters outside 1..127 or MIN_GREEN>MAX_GREEN are elaboration errors.

Reset
REQ-027 rst_n low forces immediately, independent of clk: state AR_TO_NS, count=0, NS=EW=3'b100, walk=0, SW=0, all pend flags 0.
REQ-028 Reset mid-phase (including mid-yellow) takes effect immediately with no yellow completion.
REQ-029 After rst_n release, AR_TO_NS runs ALLRED_T cycles then NS_GREEN; first clock edge after release asserts SW.

Configuration
REQ-030 Macro TL_PED_EN compiles in pedestrian service; ped_req sets sticky ped_pend.
REQ-031 With TL_PED_EN: yellow exit with ped_pend=1 enters PED_WALK (walk=1, PED_T cycles, ped_pend cleared on entry), then AR_TO_<other>; ped_pend alone also ends a green under REQ-020 rules.
REQ-032 Without TL_PED_EN: PED_WALK absent, ped_req unconnected internally, walk tied 0.

Structure
REQ-033 Package tl_pkg holds the state enum, lamp constants (LAMP_RED/YELLOW/GREEN) and the 7-bit count type.
REQ-034 Sub-module phase_timer (restart, count, saturate at 127) supplies count; FSM stays in traffic_phase_scheduler.

Verification
REQ-035 Reset release, no sensors -> NS=3'b100 for 2 cycles, then NS=3'b001, EW=3'b100 held 500 cycles, SW pulsed twice.
REQ-036 ew_sensor one-cycle pulse at NS count=5 -> NS yellow at count=19, 5 yellow cycles, 2 all-red, EW=3'b001.
REQ-037 ew_sensor at NS count=40 -> NS yellow on next cycle (count>=19); ns_sensor during EW_GREEN count=30 -> return after 5+2 cycles.
REQ-038 Both sensors held high -> steady alternation, each green exactly 20 cycles; lamps never both non-red.
REQ-039 rst_n low at NS_YELLOW count=2 -> NS=EW=3'b100 before next clk edge, count=0.
REQ-040 TL_PED_EN, ped_req during NS_GREEN count=25 -> 5 yellow, walk=1 for 15 cycles, 2 all-red, EW_GREEN; without macro walk stays 0.
